// File: rtl/parking_pkg.sv
// Shared parking-lot definitions.
// Holds the entry-gate state encoding, the default lot sizing constants used
// by the entry controller, exit controller and display, and a small helper
// for parameter range checks.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    OPEN       = 2'd1,
    WAIT_CLEAR = 2'd2
  } gate_state_e;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_CAPACITY    = 200;
  localparam int DEF_OPEN_CYCLES = 16;
  localparam int DEF_TIMER_W     = 8;

  // True when value is in 1 .. 2**width-1, i.e. representable and non-zero.
  function automatic bit fits_width(input longint value, input int width);
    return (value >= 1) && (value <= ((longint'(1) << width) - 1));
  endfunction

endpackage

// File: rtl/occupancy_counter.sv
// Saturating occupancy counter for the parking lot.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   inc          : a car was admitted this cycle
//   dec          : a car left the lot this cycle
//   occupancy    : cars inside (registered)
//   free_spaces  : CAPACITY - occupancy (registered)
//   full         : occupancy == CAPACITY (registered)
//   underflow    : 1-cycle pulse, dec seen while occupancy was 0
module occupancy_counter
  import parking_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int CAPACITY = DEF_CAPACITY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] occupancy,
  output logic [CNT_W-1:0] free_spaces,
  output logic             full,
  output logic             underflow
);

  if (!fits_width(CAPACITY, CNT_W)) begin : g_bad_capacity
    $error("occupancy_counter: CAPACITY out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] CAP_V = CNT_W'(CAPACITY);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] free_q, free_d;
  logic             full_q, full_d;
  logic             underflow_q, underflow_d;
  logic             dec_ok;

  always_comb begin
    occ_d       = occ_q;
    dec_ok      = dec && (occ_q != '0);
    // An exit at zero occupancy is reported but never wraps the count.
    underflow_d = dec && (occ_q == '0);
    case ({inc, dec_ok})
      2'b10:   occ_d = occ_q + ONE;
      2'b01:   occ_d = occ_q - ONE;
      default: occ_d = occ_q;   // idle, or entry and exit cancel out
    endcase
    // Status derives from the next count so it moves together with occupancy.
    full_d = (occ_d == CAP_V);
    free_d = CAP_V - occ_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= '0;
      free_q      <= CAP_V;
      full_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      free_q      <= free_d;
      full_q      <= full_d;
      underflow_q <= underflow_d;
    end
  end

  assign occupancy   = occ_q;
  assign free_spaces = free_q;
  assign full        = full_q;
  assign underflow   = underflow_q;

endmodule

// File: rtl/entry_gate_controller.sv
// Parking entry barrier controller.
// Registered gate FSM (IDLE -> OPEN -> WAIT_CLEAR), open-window timer,
// reject edge detector and an occupancy counter sub-block.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   entry_req    : level, car present at entry sensor
//   entry_pass   : pulse, car cleared the barrier
//   exit_pulse   : pulse, car left the lot
//   enable       : gate-open command (registered)
//   full         : lot full
//   occupancy    : cars inside
//   free_spaces  : CAPACITY - occupancy
//   reject       : pulse, new request refused because full
//   timeout_err  : pulse, gate closed without a pass
//   exit_err     : pulse, exit seen with empty lot
module entry_gate_controller
  import parking_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int OPEN_CYCLES = DEF_OPEN_CYCLES,
  parameter int TIMER_W     = DEF_TIMER_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_req,
  input  logic             entry_pass,
  input  logic             exit_pulse,
  output logic             enable,
  output logic             full,
  output logic [CNT_W-1:0] occupancy,
  output logic [CNT_W-1:0] free_spaces,
  output logic             reject,
  output logic             timeout_err,
  output logic             exit_err
);

  if (!fits_width(CAPACITY, CNT_W)) begin : g_bad_capacity
    $error("entry_gate_controller: CAPACITY must be 1 .. 2**CNT_W-1");
  end
  if (OPEN_CYCLES < 1) begin : g_bad_open_min
    $error("entry_gate_controller: OPEN_CYCLES must be at least 1");
  end
  if (!fits_width(OPEN_CYCLES, TIMER_W)) begin : g_bad_open_max
    $error("entry_gate_controller: OPEN_CYCLES must fit in TIMER_W");
  end

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  gate_state_e        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               req_q, req_d;       // previous entry_req, for edge detect
  logic               enable_q, enable_d;
  logic               reject_q, reject_d;
  logic               timeout_q, timeout_d;
  logic               inc;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    reject_d  = 1'b0;
    timeout_d = 1'b0;
    inc       = 1'b0;
    req_d     = entry_req;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (entry_req && !full) begin
          state_d = OPEN;
        end else if (entry_req && !req_q && full) begin
          // Only a fresh arrival is refused; a held request waits silently
          // and is admitted as soon as a space frees up.
          reject_d = 1'b1;
        end
      end
      OPEN: begin
        if (entry_pass) begin
          inc     = 1'b1;
          state_d = WAIT_CLEAR;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          state_d   = WAIT_CLEAR;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
      WAIT_CLEAR: begin
        // Hold the gate shut until the sensor clears so one car is never
        // admitted twice.
        timer_d = '0;
        if (!entry_req) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
    enable_d = (state_d == OPEN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      req_q     <= 1'b0;
      enable_q  <= 1'b0;
      reject_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      req_q     <= req_d;
      enable_q  <= enable_d;
      reject_q  <= reject_d;
      timeout_q <= timeout_d;
    end
  end

  occupancy_counter #(
    .CNT_W    (CNT_W),
    .CAPACITY (CAPACITY)
  ) u_occ (
    .clk         (clk),
    .rst_n       (rst_n),
    .inc         (inc),
    .dec         (exit_pulse),
    .occupancy   (occupancy),
    .free_spaces (free_spaces),
    .full        (full),
    .underflow   (exit_err)
  );

  assign enable      = enable_q;
  assign reject      = reject_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_entry_gate_controller.sv
// Randomized scoreboard bench for entry_gate_controller.
module tb_entry_gate_controller;

  localparam int CNT_W       = 8;
  localparam int CAPACITY    = 6;
  localparam int OPEN_CYCLES = 16;
  localparam int TIMER_W     = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             entry_req, entry_pass, exit_pulse;
  logic             enable, full, reject, timeout_err, exit_err;
  logic [CNT_W-1:0] occupancy, free_spaces;

  always #5 clk = ~clk;

  entry_gate_controller #(
    .CNT_W       (CNT_W),
    .CAPACITY    (CAPACITY),
    .OPEN_CYCLES (OPEN_CYCLES),
    .TIMER_W     (TIMER_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .entry_req   (entry_req),
    .entry_pass  (entry_pass),
    .exit_pulse  (exit_pulse),
    .enable      (enable),
    .full        (full),
    .occupancy   (occupancy),
    .free_spaces (free_spaces),
    .reject      (reject),
    .timeout_err (timeout_err),
    .exit_err    (exit_err)
  );

  typedef struct {
    int en, fl, occ, fr, rej, to, ee;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   in_reset;

  // Reference model: gate mode 0 closed/idle, 1 open, 2 waiting for sensor clear.
  int m_mode, m_age, m_occ;
  bit m_prev_req;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_mode = 0; m_age = 0; m_occ = 0; m_prev_req = 1'b0;
  endfunction

  // Advance one clock edge using the inputs the DUT sampled at that edge.
  function automatic exp_t model_step(input bit req, input bit pass, input bit ex);
    exp_t e;
    bit   was_full = (m_occ == CAPACITY);
    bit   admitted = 1'b0;
    e.rej = 0; e.to = 0; e.ee = 0;
    if (m_mode == 0) begin
      if (req && !was_full) begin
        m_mode = 1; m_age = 0;
      end else if (req && !m_prev_req && was_full) begin
        e.rej = 1;
      end
    end else if (m_mode == 1) begin
      if (pass) begin
        admitted = 1'b1; m_mode = 2;
      end else if (m_age == OPEN_CYCLES - 1) begin
        e.to = 1; m_mode = 2;
      end else begin
        m_age++;
      end
    end else if (!req) begin
      m_mode = 0;
    end
    m_prev_req = req;
    if (ex) begin
      if (m_occ == 0) e.ee = 1;
      else m_occ--;
    end
    if (admitted) m_occ++;
    e.en  = (m_mode == 1) ? 1 : 0;
    e.occ = m_occ;
    e.fr  = CAPACITY - m_occ;
    e.fl  = (m_occ == CAPACITY) ? 1 : 0;
    return e;
  endfunction

  // Monitor: outputs are presented every cycle; compare away from the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_underrun", 0, 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("enable",      int'(enable),      e.en);
          chk("full",        int'(full),        e.fl);
          chk("occupancy",   int'(occupancy),   e.occ);
          chk("free_spaces", int'(free_spaces), e.fr);
          chk("reject",      int'(reject),      e.rej);
          chk("timeout_err", int'(timeout_err), e.to);
          chk("exit_err",    int'(exit_err),    e.ee);
        end
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_enable"},      int'(enable),      0);
    chk({tag, "_occupancy"},   int'(occupancy),   0);
    chk({tag, "_free_spaces"}, int'(free_spaces), CAPACITY);
    chk({tag, "_full"},        int'(full),        0);
    chk({tag, "_reject"},      int'(reject),      0);
    chk({tag, "_timeout_err"}, int'(timeout_err), 0);
    chk({tag, "_exit_err"},    int'(exit_err),    0);
  endtask

  // One clock: model the edge, queue the expectation, then drive new inputs.
  task automatic run_cycle(input int pass_pct, input int exit_pct);
    @(posedge clk);
    exp_q.push_back(model_step(entry_req, entry_pass, exit_pulse));
    #1;
    if ($urandom_range(99) < 12) entry_req = ~entry_req;
    entry_pass = ((m_mode == 1) && ($urandom_range(99) < pass_pct)) ||
                 ($urandom_range(99) < 3);
    exit_pulse = ($urandom_range(99) < exit_pct);
  endtask

  initial begin
    in_reset   = 1'b1;
    rst_n      = 1'b0;
    entry_req  = 1'b0;
    entry_pass = 1'b0;
    exit_pulse = 1'b0;
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk); #2;
    rst_n    = 1'b1;
    in_reset = 1'b0;

    for (int p = 0; p < 12; p++) begin
      int pass_pct = (p % 3 == 2) ? 0 : 30;
      int exit_pct = (p % 2 == 1) ? 4 : 25;
      if (p == 6) begin
        // Drop reset asynchronously while the gate is open with cars inside.
        for (int w = 0; w < 600; w++) begin
          if (m_mode == 1 && m_occ > 0) break;
          run_cycle(0, 2);
        end
        #2;                       // mid-cycle, away from any edge
        in_reset = 1'b1;
        rst_n    = 1'b0;
        #1;
        check_reset_values("async_reset");
        exp_q.delete();
        model_reset();
        @(negedge clk); #2;
        rst_n    = 1'b1;
        in_reset = 1'b0;
      end
      for (int c = 0; c < 250; c++) run_cycle(pass_pct, exit_pct);
    end

    @(negedge clk);
    #1;
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
